// File: rtl/ir_nec_tx.sv
// NEC IR frame transmitter (Avalon-MM slave): write DATA/REPEAT while idle to send; writes while busy are dropped and flag overrun.
// ir_out follows the FSM by one clock; readdata is one clock behind address; done/irq are sticky and visible one clock after return to idle.
module ir_nec_tx #(
  parameter int CARRIER_HALF = 658,
  parameter int UNIT_CLKS    = 28125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        ir_out
);

  localparam int UW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  state_t        state, state_nxt;
  logic [UW-1:0] unit_cnt;
  logic [3:0]    seg_cnt;
  logic [3:0]    seg_last;
  logic [4:0]    bit_idx;
  logic [CW-1:0] car_cnt;
  logic          car_phase;
  logic [31:0]   data_reg;
  logic          is_repeat;
  logic          irq_en;
  logic          invert;
  logic          done;
  logic          overrun;

  logic wr_en, frame_wr, start, unit_wrap, seg_end;
  logic is_mark, mark_start, done_set, raw;

  assign wr_en     = chipselect & ~write_n;
  assign frame_wr  = wr_en && (address == 2'd0 || address == 2'd1);
  assign start     = frame_wr && (state == IDLE);
  assign unit_wrap = (unit_cnt == UW'(UNIT_CLKS - 1));
  assign seg_end   = unit_wrap && (seg_cnt == seg_last);
  assign is_mark   = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
  assign raw       = is_mark & car_phase;
  assign done_set  = (state == STOP_MARK) && (state_nxt == IDLE);

  // Segment length in units, minus one
  always_comb begin
    seg_last = 4'd0;
    case (state)
      LEAD_MARK:  seg_last = 4'd15;
      LEAD_SPACE: seg_last = is_repeat ? 4'd3 : 4'd7;
      BIT_SPACE:  seg_last = data_reg[bit_idx] ? 4'd2 : 4'd0;
      default:    seg_last = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    mark_start = 1'b0;
    case (state)
      IDLE:       if (start)   state_nxt = LEAD_MARK;
      LEAD_MARK:  if (seg_end) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (seg_end) state_nxt = is_repeat ? STOP_MARK : BIT_MARK;
      BIT_MARK:   if (seg_end) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (seg_end) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (seg_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    // Every mark is entered from a non-mark state, so a state change into a mark is a fresh mark
    if ((state_nxt != state) &&
        (state_nxt == LEAD_MARK || state_nxt == BIT_MARK || state_nxt == STOP_MARK))
      mark_start = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_cnt  <= '0;
      seg_cnt   <= '0;
      bit_idx   <= '0;
      car_cnt   <= '0;
      car_phase <= 1'b0;
      data_reg  <= '0;
      is_repeat <= 1'b0;
      irq_en    <= 1'b0;
      invert    <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      ir_out    <= 1'b0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      if (state == IDLE || unit_wrap) unit_cnt <= '0;
      else                            unit_cnt <= unit_cnt + 1'b1;

      if (state == IDLE || seg_end) seg_cnt <= '0;
      else if (unit_wrap)           seg_cnt <= seg_cnt + 1'b1;

      if (state == IDLE)                        bit_idx <= '0;
      else if (state == BIT_SPACE && seg_end)   bit_idx <= bit_idx + 1'b1;

      if (mark_start) begin
        car_cnt   <= '0;
        car_phase <= 1'b1;
      end else if (car_cnt == CW'(CARRIER_HALF - 1)) begin
        car_cnt   <= '0;
        car_phase <= ~car_phase;
      end else begin
        car_cnt   <= car_cnt + 1'b1;
      end

      if (start) begin
        is_repeat <= (address == 2'd1);
        if (address == 2'd0) data_reg <= writedata;
      end

      if (wr_en && address == 2'd3) begin
        irq_en <= writedata[0];
        invert <= writedata[1];
      end

      // Set has priority over a same-cycle clear
      if (done_set)                          done <= 1'b1;
      else if (wr_en && address == 2'd2)     done <= 1'b0;
      if (frame_wr && state != IDLE)         overrun <= 1'b1;
      else if (wr_en && address == 2'd2)     overrun <= 1'b0;

      ir_out <= raw ^ invert;
      irq    <= done & irq_en;

      case (address)
        2'd0:    readdata <= data_reg;
        2'd2:    readdata <= {29'd0, overrun, done, state != IDLE};
        2'd3:    readdata <= {30'd0, invert, irq_en};
        default: readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx: table of frames plus random frames, each checked clock by clock
// against a waveform built from the NEC segment rules.
module tb_ir_nec_tx;
  localparam int CH   = 2;
  localparam int UNIT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        ir_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_wave[$];

  always #5 clk = ~clk;

  ir_nec_tx #(.CARRIER_HALF(CH), .UNIT_CLKS(UNIT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .ir_out(ir_out)
  );

  typedef struct {
    bit          rep;
    logic [31:0] word;
    logic [1:0]  ctrl;
    int          units;
    bit          clr_at_done;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick;
    d = readdata;
  endtask

  // A mark is carrier starting high, toggling every CH clocks; a space is low
  function automatic void push_seg(bit mark, int units, bit inv);
    for (int k = 0; k < units * UNIT; k++)
      exp_wave.push_back((mark && ((k / CH) % 2 == 0)) ^ inv);
  endfunction

  function automatic int build_wave(bit rep, logic [31:0] w, bit inv);
    int units = 0;
    exp_wave.delete();
    push_seg(1'b1, 16, inv); units += 16;
    if (rep) begin
      push_seg(1'b0, 4, inv); units += 4;
    end else begin
      push_seg(1'b0, 8, inv); units += 8;
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, 1, inv);
        push_seg(1'b0, w[i] ? 3 : 1, inv);
        units += w[i] ? 4 : 2;
      end
    end
    push_seg(1'b1, 1, inv); units += 1;
    return units;
  endfunction

  // Sends one frame and checks ir_out every clock plus busy/done/irq around the end.
  // exp_units < 0 takes the length from the model; tail = idle clocks checked afterwards.
  task automatic run_frame(input string name, input bit rep, input logic [31:0] w,
                           input logic [1:0] ctrl, input int exp_units, input bit clr_first,
                           input bit clr_at_done, input int ovr_at, input bit exp_ovr,
                           input int tail);
    int   units, len, bad, first_bad;
    logic exp_bit;
    units = build_wave(rep, w, ctrl[1]);
    len   = ((exp_units < 0) ? units : exp_units) * UNIT;
    bad = 0; first_bad = -1;
    if (clr_first) wr(2'd2, 32'd0);
    wr(rep ? 2'd1 : 2'd0, w);
    address = 2'd2;
    for (int t = 1; t <= len + tail; t++) begin
      tick;
      exp_bit = (t - 1 < exp_wave.size()) ? exp_wave[t - 1] : ctrl[1];
      if (ir_out !== exp_bit) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
      if (ovr_at > 0 && t == ovr_at + 1) begin
        check({name, " data kept"}, readdata, w);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
      end
      if (ovr_at > 0 && t == ovr_at) begin
        address = 2'd0; writedata = 32'hFFFF_FFFF; chipselect = 1'b1; write_n = 1'b0;
      end
      if (t == len) begin
        check({name, " busy at end"}, readdata[0], 1'b1);
        if (clr_first) check({name, " irq before done"}, irq, 1'b0);
        if (clr_at_done) begin chipselect = 1'b0; write_n = 1'b1; end
      end
      if (t == len + 1) begin
        check({name, " status after"}, readdata, {29'd0, exp_ovr, 1'b1, 1'b0});
        check({name, " irq after"}, irq, ctrl[0]);
      end
      if (clr_at_done && t == len - 1) begin
        writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s wave: %0d wrong clocks, first at clock %0d, expected %0d clocks", name, bad, first_bad, len);
    end
  endtask

  initial begin
    vec_t        tbl[4];
    logic [31:0] d;
    logic [31:0] w;
    logic [1:0]  c;

    tbl[0] = '{rep: 1'b0, word: 32'h00FF00FF, ctrl: 2'd0, units: 121, clr_at_done: 1'b0};
    tbl[1] = '{rep: 1'b1, word: 32'h0,        ctrl: 2'd0, units: 21,  clr_at_done: 1'b0};
    tbl[2] = '{rep: 1'b0, word: 32'h0,        ctrl: 2'd3, units: 89,  clr_at_done: 1'b1};
    tbl[3] = '{rep: 1'b0, word: 32'hFFFFFFFF, ctrl: 2'd0, units: 153, clr_at_done: 1'b0};

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    repeat (3) tick;
    check("reset ir_out", ir_out, 1'b0);
    check("reset irq", irq, 1'b0);
    check("reset readdata", readdata, 32'd0);
    reset_n = 1'b1;
    tick;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      check($sformatf("reset reg%0d", a), d, 32'd0);
    end

    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d);
    check("control mask", d, 32'h3);
    wr(2'd1, 32'h0);  // starts a repeat; let it finish
    repeat (21 * UNIT + 2) tick;
    wr(2'd3, 32'h0);

    foreach (tbl[i]) begin
      wr(2'd3, {30'd0, tbl[i].ctrl});
      run_frame($sformatf("vec%0d", i), tbl[i].rep, tbl[i].word, tbl[i].ctrl,
                tbl[i].units, 1'b1, tbl[i].clr_at_done, 0, 1'b0, 6);
    end

    wr(2'd3, 32'h0);
    run_frame("overrun", 1'b0, 32'h12345678, 2'd0, -1, 1'b1, 1'b0, 100, 1'b1, 2);
    rd(2'd0, d);
    check("overrun data", d, 32'h12345678);
    wr(2'd2, 32'h5);
    rd(2'd2, d);
    check("status cleared", d, 32'd0);

    run_frame("b2b first", 1'b0, 32'hA5A5A5A5, 2'd0, -1, 1'b1, 1'b0, 0, 1'b0, 0);
    run_frame("b2b second", 1'b0, 32'h0000FFFF, 2'd0, -1, 1'b0, 1'b0, 0, 1'b0, 4);

    for (int r = 0; r < 5; r++) begin
      w = $urandom;
      c = 2'($urandom_range(0, 3));
      wr(2'd3, {30'd0, c});
      run_frame($sformatf("rand%0d", r), 1'b0, w, c, -1, 1'b1, 1'b0, 0, 1'b0, 3);
    end

    // Abandon a frame with reset while done, irq_en and invert are all set
    wr(2'd3, 32'h3);
    wr(2'd0, 32'h00FF00FF);
    address = 2'd3;
    repeat (30 * UNIT - 1) tick;
    check("pre-reset ir_out", ir_out, 1'b1);
    check("pre-reset irq", irq, 1'b1);
    check("pre-reset readdata", readdata, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    check("async reset ir_out", ir_out, 1'b0);
    check("async reset irq", irq, 1'b0);
    check("async reset readdata", readdata, 32'd0);
    tick;
    reset_n = 1'b1;
    rd(2'd2, d);
    check("status after reset", d, 32'd0);
    rd(2'd3, d);
    check("control after reset", d, 32'd0);
    repeat (150 * UNIT) tick;
    check("no done after reset", readdata, 32'd0);
    check("idle ir_out after reset", ir_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
